// File: rtl/sc_speed_pkg.sv
// Shared types and default constants for the game-speed scheduler.
package sc_speed_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_e;

  localparam int unsigned DATAWIDTH_DEF = 23;
  localparam int unsigned TICK_CNT_W    = 8;

  // Default terminal counts, slowest to fastest
  localparam logic [DATAWIDTH_DEF-1:0] TERM_L0_DEF = 23'h7FFFFF;
  localparam logic [DATAWIDTH_DEF-1:0] TERM_L1_DEF = 23'h400000;
  localparam logic [DATAWIDTH_DEF-1:0] TERM_L2_DEF = 23'h3E0000;
  localparam logic [DATAWIDTH_DEF-1:0] TERM_L3_DEF = 23'h200000;

  localparam logic [1:0] LEVEL_MAX = 2'd3;

endpackage

// File: rtl/sc_speed_divider.sv
// Speed counter: counts while enabled, wraps to zero once it reaches or passes the terminal.
module sc_speed_divider
  import sc_speed_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DATAWIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [DATAWIDTH-1:0] term,
  output logic [DATAWIDTH-1:0] count,
  output logic                 wrap_c
);

  // ">=" so a level change that lowers term below the count still wraps
  assign wrap_c = (count >= term);

  // Counter register; clear wins over counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap_c ? '0 : count + DATAWIDTH'(1);
    end
  end

endmodule

// File: rtl/sc_speed_scheduler.sv
// Game-speed controller: run/pause/over FSM, per-level terminal select, tick and level advance.
module sc_speed_scheduler
  import sc_speed_pkg::*;
#(
  parameter int unsigned          DATAWIDTH       = DATAWIDTH_DEF,
  parameter logic [DATAWIDTH-1:0] TERM_L0         = TERM_L0_DEF,
  parameter logic [DATAWIDTH-1:0] TERM_L1         = TERM_L1_DEF,
  parameter logic [DATAWIDTH-1:0] TERM_L2         = TERM_L2_DEF,
  parameter logic [DATAWIDTH-1:0] TERM_L3         = TERM_L3_DEF,
  parameter int unsigned          TICKS_PER_LEVEL = 32
) (
  input  logic                 SC_SPEEDSCHEDULER_CLOCK_50,
  input  logic                 SC_SPEEDSCHEDULER_RESET_InLow,
  input  logic                 SC_SPEEDSCHEDULER_start_InHigh,
  input  logic                 SC_SPEEDSCHEDULER_pause_InHigh,
  input  logic                 SC_SPEEDSCHEDULER_over_InHigh,
  input  logic                 SC_SPEEDSCHEDULER_levelup_InHigh,
  output logic                 SC_SPEEDSCHEDULER_tick_OutLow,
  output logic [1:0]           SC_SPEEDSCHEDULER_level_OutBus,
  output logic [DATAWIDTH-1:0] SC_SPEEDSCHEDULER_count_OutBus,
  output logic                 SC_SPEEDSCHEDULER_run_OutHigh
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_PAUSE = PAUSE;
  localparam logic [1:0] ST_OVER  = OVER;

  localparam logic [TICK_CNT_W-1:0] TICK_LAST = TICK_CNT_W'(TICKS_PER_LEVEL - 1);

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic                  pause;
  logic                  over;
  logic                  levelup;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [1:0]            level;
  logic [1:0]            level_nxt;
  logic [TICK_CNT_W-1:0] tick_cnt;
  logic [TICK_CNT_W-1:0] tick_cnt_nxt;
  logic                  tick_nxt;
  logic                  lvl_up;
  logic                  cnt_en;
  logic                  cnt_clr;
  logic [DATAWIDTH-1:0]  term;
  logic                  wrap_c;

  assign clk     = SC_SPEEDSCHEDULER_CLOCK_50;
  assign rst_n   = SC_SPEEDSCHEDULER_RESET_InLow;
  assign start   = SC_SPEEDSCHEDULER_start_InHigh;
  assign pause   = SC_SPEEDSCHEDULER_pause_InHigh;
  assign over    = SC_SPEEDSCHEDULER_over_InHigh;
  assign levelup = SC_SPEEDSCHEDULER_levelup_InHigh;

  assign SC_SPEEDSCHEDULER_level_OutBus = level;

  // Terminal count for the current level
  always_comb begin
    term = TERM_L0;
    case (level)
      2'd1:    term = TERM_L1;
      2'd2:    term = TERM_L2;
      2'd3:    term = TERM_L3;
      default: term = TERM_L0;
    endcase
  end

  sc_speed_divider #(
    .DATAWIDTH (DATAWIDTH)
  ) u_divider (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .term   (term),
    .count  (SC_SPEEDSCHEDULER_count_OutBus),
    .wrap_c (wrap_c)
  );

  // Next state, counter control, level/tick_cnt update; priority over > start > pause > levelup
  always_comb begin
    state_nxt    = state;
    level_nxt    = level;
    tick_cnt_nxt = tick_cnt;
    tick_nxt     = 1'b1;
    lvl_up       = 1'b0;
    cnt_en       = 1'b0;
    cnt_clr      = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start && !over) begin
          state_nxt    = ST_RUN;
          level_nxt    = 2'd0;
          tick_cnt_nxt = '0;
          cnt_clr      = 1'b1;
        end
      end
      ST_RUN: begin
        if (over) begin
          state_nxt = ST_OVER;
        end else if (pause) begin
          state_nxt = ST_PAUSE;
        end else begin
          cnt_en = 1'b1;
          lvl_up = levelup;
          if (wrap_c) begin
            tick_nxt = 1'b0;
            if (tick_cnt == TICK_LAST) begin
              lvl_up       = 1'b1;
              tick_cnt_nxt = '0;
            end else begin
              tick_cnt_nxt = tick_cnt + TICK_CNT_W'(1);
            end
          end
          if (levelup) begin
            tick_cnt_nxt = '0;
          end
          // Only a real level change restarts the period
          if (lvl_up && (level != LEVEL_MAX)) begin
            level_nxt = level + 2'd1;
            cnt_clr   = 1'b1;
          end
        end
      end
      ST_PAUSE: begin
        if (over) begin
          state_nxt = ST_OVER;
        end else if (!pause) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Level, tick counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level                         <= 2'd0;
      tick_cnt                      <= '0;
      SC_SPEEDSCHEDULER_tick_OutLow <= 1'b1;
      SC_SPEEDSCHEDULER_run_OutHigh <= 1'b0;
    end else begin
      level                         <= level_nxt;
      tick_cnt                      <= tick_cnt_nxt;
      SC_SPEEDSCHEDULER_tick_OutLow <= tick_nxt;
      SC_SPEEDSCHEDULER_run_OutHigh <= (state_nxt == ST_RUN);
    end
  end

endmodule

// File: tb/tb_sc_speed_scheduler.sv
// Bench for sc_speed_scheduler: directed scenarios plus random stimulus against a behavioural model.
module tb_sc_speed_scheduler;

  localparam int TPL = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        over = 1'b0;
  logic        levelup = 1'b0;
  logic        tick;
  logic [1:0]  level;
  logic [22:0] count;
  logic        run;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  sc_speed_scheduler #(
    .DATAWIDTH       (23),
    .TERM_L0         (23'd9),
    .TERM_L1         (23'd7),
    .TERM_L2         (23'd5),
    .TERM_L3         (23'd3),
    .TICKS_PER_LEVEL (TPL)
  ) dut (
    .SC_SPEEDSCHEDULER_CLOCK_50       (clk),
    .SC_SPEEDSCHEDULER_RESET_InLow    (rst_n),
    .SC_SPEEDSCHEDULER_start_InHigh   (start),
    .SC_SPEEDSCHEDULER_pause_InHigh   (pause),
    .SC_SPEEDSCHEDULER_over_InHigh    (over),
    .SC_SPEEDSCHEDULER_levelup_InHigh (levelup),
    .SC_SPEEDSCHEDULER_tick_OutLow    (tick),
    .SC_SPEEDSCHEDULER_level_OutBus   (level),
    .SC_SPEEDSCHEDULER_count_OutBus   (count),
    .SC_SPEEDSCHEDULER_run_OutHigh    (run)
  );

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Behavioural model: game mode, position within the period, ticks seen at this level
  int periods[4] = '{10, 8, 6, 4};
  int m_mode = 0;   // 0 idle, 1 running, 2 paused, 3 over
  int m_pos = 0;
  int m_level = 0;
  int m_seen = 0;
  int m_tick = 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_pos = 0; m_level = 0; m_seen = 0; m_tick = 1;
    end else begin
      m_tick = 1;
      if (m_mode == 0 || m_mode == 3) begin
        if (start && !over) begin
          m_mode = 1; m_pos = 0; m_level = 0; m_seen = 0;
        end
      end else if (m_mode == 2) begin
        if (over) m_mode = 3;
        else if (!pause) m_mode = 1;
      end else if (over) begin
        m_mode = 3;
      end else if (pause) begin
        m_mode = 2;
      end else begin
        bit bump;
        bump = levelup;
        if (m_pos >= periods[m_level] - 1) begin
          m_tick = 0;
          m_pos = 0;
          m_seen = (m_seen + 1) % TPL;
          if (m_seen == 0) bump = 1;
        end else begin
          m_pos++;
        end
        if (levelup) m_seen = 0;
        if (bump && m_level < 3) begin
          m_level++;
          m_pos = 0;
        end
      end
    end
  end

  // Single compare process, sampled on the falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_tick", int'(tick), m_tick);
      check("model_level", int'(level), m_level);
      check("model_count", int'(count), m_pos);
      check("model_run", int'(run), (m_mode == 1) ? 1 : 0);
    end
  end

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_over();
    over = 1'b1; @(negedge clk); over = 1'b0;
  endtask

  task automatic pulse_levelup();
    levelup = 1'b1; @(negedge clk); levelup = 1'b0;
  endtask

  // Cycles (falling edges) until tick is seen low; bounded
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b0 && n < 200);
    if (tick !== 1'b0) check("wait_tick_timeout", 0, 1);
  endtask

  task automatic wait_count(input int val);
    int n;
    n = 0;
    while (!(run === 1'b1 && int'(count) == val) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("wait_count_timeout", int'(count), val);
  endtask

  initial begin
    int n;
    int lvl;

    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_tick", int'(tick), 1);
    check("reset_level", int'(level), 0);
    check("reset_count", int'(count), 0);
    check("reset_run", int'(run), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_run", int'(run), 0);

    // Free run from start through all levels
    pulse_start();
    check("start_count", int'(count), 0);
    lvl = 0;
    for (int i = 1; i <= 20; i++) begin
      wait_tick(n);
      check("tick_interval", n, periods[lvl]);
      lvl = (i / TPL > 3) ? 3 : i / TPL;
      check("level_after_tick", int'(level), lvl);
    end

    // Game over holds level and drops run/tick
    pulse_over();
    check("over_run", int'(run), 0);
    check("over_tick", int'(tick), 1);
    check("over_level", int'(level), 3);
    repeat (3) @(negedge clk);
    pulse_start();
    check("restart_level", int'(level), 0);
    check("restart_count", int'(count), 0);
    check("restart_run", int'(run), 1);

    // Pause mid-period at count 6
    wait_count(6);
    pause = 1'b1;
    repeat (20) @(negedge clk);
    check("pause_count", int'(count), 6);
    check("pause_run", int'(run), 0);
    pause = 1'b0;
    n = 0;
    while (run !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("resume_count", int'(count), 6);
    wait_tick(n);
    check("resume_tick_delay", n, 4);

    // External level-up at count 8
    pulse_over();
    pulse_start();
    wait_count(8);
    pulse_levelup();
    check("levelup_level", int'(level), 1);
    check("levelup_count", int'(count), 0);

    // External level-up coincident with automatic level-up
    pulse_over();
    pulse_start();
    repeat (3) wait_tick(n);
    wait_count(9);
    pulse_levelup();
    check("coincident_level", int'(level), 1);
    check("coincident_tick", int'(tick), 0);

    // Asynchronous reset while tick is low
    wait_tick(n);
    #1 rst_n = 1'b0;
    #1;
    check("async_tick", int'(tick), 1);
    check("async_level", int'(level), 0);
    check("async_count", int'(count), 0);
    check("async_run", int'(run), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random stimulus against the model
    for (int c = 0; c < 4000; c++) begin
      start   = ($urandom_range(0, 15) == 0);
      over    = ($urandom_range(0, 79) == 0);
      levelup = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 24) == 0) pause = ~pause;
      @(negedge clk);
    end
    start = 1'b0; over = 1'b0; levelup = 1'b0; pause = 1'b0;
    @(negedge clk);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
